fft_butterfly: RTL

FFT_BUTTERFLY -- requirements
Module: fft_butterfly

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/fft_cmul.sv | 73 +++++++
 rtl/fft_butterfly.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: default Q widths and the derived datapath constants shared by the
// butterfly and its complex multiplier. The widths are functions of the Q
// parameters, so a non-default instance derives its own sizes.
package fft_pkg;

  localparam int Q_IN_DEF   = 15;
  localparam int Q_DATA_DEF = 15;
  localparam int Q_OUT_DEF  = 15;
  localparam int N_DEF      = 8;

  // Full-width product of a sample and a twiddle.
  function automatic int prod_w(input int q_in, input int q_data);
    return q_in + q_data + 2;
  endfunction

  // Sum or difference of two full-width products.
  function automatic int sum_w(input int q_in, input int q_data);
    return q_in + q_data + 3;
  endfunction

  // Rounded product w*b, one bit wider than a sample.
  function automatic int p_w(input int q_in);
    return q_in + 2;
  endfunction

  // a +/- p before reduction to the output width.
  function automatic int s3_w(input int q_in);
    return q_in + 3;
  endfunction

  // Half an LSB of the rounded product, added before the right shift.
  function automatic longint rnd_const(input int q_data);
    return longint'(1) << (q_data - 1);
  endfunction

  // Saturation bounds of the output word.
  function automatic longint sat_max(input int q_out);
    return (longint'(1) << q_out) - 1;
  endfunction

  function automatic longint sat_min(input int q_out);
    return -(longint'(1) << q_out);
  endfunction

  // Pair counter width for an N-point frame.
  function automatic int cnt_w(input int n);
    return $clog2(n / 2);
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: two-stage pipelined complex multiplier p = w*b with rounding.
// Stage 1 registers the four partial products at full width; stage 2 forms
// the real/imag sums, adds half an LSB and shifts down by Q_DATA.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int Q_IN   = Q_IN_DEF,
  parameter int Q_DATA = Q_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic signed [Q_IN:0]   b_re_i,
  input  logic signed [Q_IN:0]   b_im_i,
  input  logic signed [Q_DATA:0] w_re_i,
  input  logic signed [Q_DATA:0] w_im_i,
  output logic                 valid_o,
  output logic signed [Q_IN+1:0] p_re_o,
  output logic signed [Q_IN+1:0] p_im_o
);

  localparam int PROD_W = prod_w(Q_IN, Q_DATA);
  localparam int SUM_W  = sum_w(Q_IN, Q_DATA);
  localparam int P_W    = p_w(Q_IN);
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(rnd_const(Q_DATA));

  logic                     v1_q, v2_q;
  logic signed [PROD_W-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [SUM_W-1:0]  pr_sum, pi_sum;
  logic signed [P_W-1:0]    p_re_d, p_im_d, p_re_q, p_im_q;

  // Valid bits are the only multiplier state that must clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
    end
  end

  // Stage 1: capture the four partial products of an accepted operand.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      rr_q <= PROD_W'(b_re_i) * PROD_W'(w_re_i);
      ii_q <= PROD_W'(b_im_i) * PROD_W'(w_im_i);
      ri_q <= PROD_W'(b_re_i) * PROD_W'(w_im_i);
      ir_q <= PROD_W'(b_im_i) * PROD_W'(w_re_i);
    end
  end

  // Stage 2 combinational: complex sums, round half up, keep Q_IN+2 bits.
  always_comb begin
    pr_sum = {rr_q[PROD_W-1], rr_q} - {ii_q[PROD_W-1], ii_q};
    pi_sum = {ri_q[PROD_W-1], ri_q} + {ir_q[PROD_W-1], ir_q};
    p_re_d = P_W'((pr_sum + RND) >>> Q_DATA);
    p_im_d = P_W'((pi_sum + RND) >>> Q_DATA);
  end

  // Stage 2 register: rounded product, loaded only for a live butterfly.
  always_ff @(posedge clk) begin
    if (v1_q) begin
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

  assign valid_o = v2_q;
  assign p_re_o  = p_re_q;
  assign p_im_o  = p_im_q;

endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly X0 = a + w*b, X1 = a - w*b, three
// pipeline stages, one butterfly per cycle, no backpressure.
// Valid/ready: there is no ready; valid_in qualifies all inputs for the one
// cycle it is high, and valid_out qualifies the outputs for exactly one cycle
// three edges later. Outputs hold their last value while valid_out is low.
// Build option: define FFT_BFLY_SAT_EN to saturate the final sums; otherwise
// they wrap to the output width.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int Q_IN   = Q_IN_DEF,
  parameter int Q_DATA = Q_DATA_DEF,
  parameter int Q_OUT  = Q_OUT_DEF,
  parameter int N      = N_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic signed [Q_IN:0]   data_in_real_0,
  input  logic signed [Q_IN:0]   data_in_imag_0,
  input  logic signed [Q_IN:0]   data_in_real_1,
  input  logic signed [Q_IN:0]   data_in_imag_1,
  input  logic signed [Q_DATA:0] coeff_in_real,
  input  logic signed [Q_DATA:0] coeff_in_imag,
  output logic                   valid_out,
  output logic signed [Q_OUT:0]  data_out_real_0,
  output logic signed [Q_OUT:0]  data_out_imag_0,
  output logic signed [Q_OUT:0]  data_out_real_1,
  output logic signed [Q_OUT:0]  data_out_imag_1,
  output logic                   frame_done
);

  localparam int P_W   = p_w(Q_IN);
  localparam int S3_W  = s3_w(Q_IN);
  localparam int OW    = Q_OUT + 1;
  localparam int CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N / 2 - 1);

`ifdef FFT_BFLY_SAT_EN
  localparam logic signed [S3_W-1:0] SAT_HI = S3_W'(sat_max(Q_OUT));
  localparam logic signed [S3_W-1:0] SAT_LO = S3_W'(sat_min(Q_OUT));

  // Clamp a stage-3 sum to the representable output range.
  function automatic logic signed [OW-1:0] sat_s3(input logic signed [S3_W-1:0] s);
    if (s > SAT_HI) return OW'(SAT_HI);
    if (s < SAT_LO) return OW'(SAT_LO);
    return OW'(s);
  endfunction
`endif

  logic signed [Q_IN:0]  a_re_s1_q, a_im_s1_q, a_re_s2_q, a_im_s2_q;
  logic                  cm_valid;
  logic signed [P_W-1:0] p_re, p_im;

  logic                  valid_out_q, frame_done_q, frame_done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [OW-1:0]  x0_re_q, x0_im_q, x1_re_q, x1_im_q;
  logic signed [OW-1:0]  x0_re_d, x0_im_d, x1_re_d, x1_im_d;

  fft_cmul #(
    .Q_IN   (Q_IN),
    .Q_DATA (Q_DATA)
  ) u_cmul (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_in),
    .b_re_i  (data_in_real_1),
    .b_im_i  (data_in_imag_1),
    .w_re_i  (coeff_in_real),
    .w_im_i  (coeff_in_imag),
    .valid_o (cm_valid),
    .p_re_o  (p_re),
    .p_im_o  (p_im)
  );

  // Delay operand a by two cycles so it meets w*b at stage 3.
  always_ff @(posedge clk) begin
    a_re_s1_q <= data_in_real_0;
    a_im_s1_q <= data_in_imag_0;
    a_re_s2_q <= a_re_s1_q;
    a_im_s2_q <= a_im_s1_q;
  end

  // Stage 3 combinational: a +/- p, reduced to the output width; pair count.
  always_comb begin
`ifdef FFT_BFLY_SAT_EN
    x0_re_d = sat_s3(S3_W'(a_re_s2_q) + S3_W'(p_re));
    x0_im_d = sat_s3(S3_W'(a_im_s2_q) + S3_W'(p_im));
    x1_re_d = sat_s3(S3_W'(a_re_s2_q) - S3_W'(p_re));
    x1_im_d = sat_s3(S3_W'(a_im_s2_q) - S3_W'(p_im));
`else
    x0_re_d = OW'(S3_W'(a_re_s2_q) + S3_W'(p_re));
    x0_im_d = OW'(S3_W'(a_im_s2_q) + S3_W'(p_im));
    x1_re_d = OW'(S3_W'(a_re_s2_q) - S3_W'(p_re));
    x1_im_d = OW'(S3_W'(a_im_s2_q) - S3_W'(p_im));
`endif
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (cm_valid) begin
      frame_done_d = (cnt_q == LAST_PAIR);
      cnt_d        = (cnt_q == LAST_PAIR) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Stage 3 register: outputs update only for a live butterfly and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      x0_re_q      <= '0;
      x0_im_q      <= '0;
      x1_re_q      <= '0;
      x1_im_q      <= '0;
    end else begin
      valid_out_q  <= cm_valid;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      if (cm_valid) begin
        x0_re_q <= x0_re_d;
        x0_im_q <= x0_im_d;
        x1_re_q <= x1_re_d;
        x1_im_q <= x1_im_d;
      end
    end
  end

  assign valid_out       = valid_out_q;
  assign frame_done      = frame_done_q;
  assign data_out_real_0 = x0_re_q;
  assign data_out_imag_0 = x0_im_q;
  assign data_out_real_1 = x1_re_q;
  assign data_out_imag_1 = x1_im_q;

endmodule
